// File: rtl/fma_norm_seq.sv
// fma_norm_seq -- multi-cycle left-normalizer for the FMA sum.
//
// Takes the positive sum significand/exponent/sign produced by the FMA adder
// and shifts the significand left until its MSB is set. Each cycle shifts by
// at most STEP bits. Shifting stops early when the exponent would drop below 1
// (denormal result), and an all-zero sum is flagged through Zero.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   InValid / InReady   operand handshake (ready only while idle)
//   Sm, Se, Ss          sum significand (W bits), exponent (NE+2, signed), sign
//   OutValid / OutReady result handshake (valid only in DONE)
//   Mf, Me, Ms, Zero    normalized significand, adjusted exponent, sign,
//                       exact-zero flag
module fma_norm_seq #(
  parameter int NF   = 52,
  parameter int NE   = 11,
  parameter int STEP = 16,
  localparam int W   = 3*NF+4,
  localparam int EW  = NE+2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          InValid,
  output logic          InReady,
  input  logic [W-1:0]  Sm,
  input  logic [EW-1:0] Se,
  input  logic          Ss,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [W-1:0]  Mf,
  output logic [EW-1:0] Me,
  output logic          Ms,
  output logic          Zero
);

  localparam int LW = $clog2(STEP+1);
  // Common compare width for the zero count and the exponent limit.
  localparam int CW = ((LW > EW) ? LW : EW) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  mf_q, mf_d;
  logic [EW-1:0] me_q, me_d;
  logic          ms_q, zero_q;

  logic [LW-1:0] lz;
  logic [EW-1:0] lim;
  logic [CW-1:0] lz_x, lim_x, amt;
  logic          stop;

  // Leading zeros of the top STEP bits; STEP when they are all zero.
  function automatic logic [LW-1:0] lzc(input logic [STEP-1:0] v);
    lzc = LW'(STEP);
    for (int i = 0; i < STEP; i++)
      if (v[i]) lzc = LW'(STEP-1-i);
  endfunction

  always_comb begin
    lz    = lzc(mf_q[W-1 -: STEP]);
    // The exponent may fall to 1 but no lower; non-positive exponents
    // allow no shift at all.
    lim   = (!me_q[EW-1] && (me_q != '0)) ? (me_q - EW'(1)) : '0;
    lz_x  = CW'(lz);
    lim_x = CW'(lim);
    amt   = (lz_x < lim_x) ? lz_x : lim_x;
    mf_d  = mf_q << amt;
    me_d  = me_q - EW'(amt);
    // A full STEP of zeros that was fully shifted means more may follow.
    stop  = (lz != LW'(STEP)) || (amt != lz_x);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mf_q    <= '0;
      me_q    <= '0;
      ms_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (InValid) begin
          mf_q    <= Sm;
          me_q    <= Se;
          ms_q    <= Ss;
          zero_q  <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: if (mf_q == '0) begin
          zero_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          mf_q <= mf_d;
          me_q <= me_d;
          if (stop) state_q <= DONE;
        end
        DONE: if (OutReady) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Mf       = mf_q;
  assign Me       = me_q;
  assign Ms       = ms_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_fma_norm_seq.sv
module tb_fma_norm_seq;

  localparam int W    = 160;
  localparam int EW   = 13;
  localparam int STEP = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          InValid, InReady, OutValid, OutReady;
  logic [W-1:0]  Sm, Mf;
  logic [EW-1:0] Se, Me;
  logic          Ss, Ms, Zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0]  sm;
    logic [EW-1:0] se;
    logic          ss;
    logic [W-1:0]  mf;
    logic [EW-1:0] me;
    logic          zero;
    int            edges;
  } vec_t;

  fma_norm_seq dut (
    .clk(clk), .reset_n(reset_n),
    .InValid(InValid), .InReady(InReady),
    .Sm(Sm), .Se(Se), .Ss(Ss),
    .OutValid(OutValid), .OutReady(OutReady),
    .Mf(Mf), .Me(Me), .Ms(Ms), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: normalize the whole value at once, clamped so the exponent
  // never goes below 1; latency is one edge per full STEP shifted plus one.
  function automatic vec_t model(input logic [W-1:0] sm, input logic [EW-1:0] se, input logic ss);
    vec_t r;
    int ltot, e, lim, s;
    r.sm = sm; r.se = se; r.ss = ss;
    e = int'($signed(se));
    if (sm == '0) begin
      r.mf = '0; r.me = se; r.zero = 1'b1; r.edges = 1;
    end else begin
      ltot = 0;
      for (int i = W-1; i >= 0; i--) begin
        if (sm[i]) break;
        ltot++;
      end
      lim = (e >= 1) ? e - 1 : 0;
      s = (ltot < lim) ? ltot : lim;
      r.mf = sm << s;
      r.me = EW'(e - s);
      r.zero = 1'b0;
      r.edges = s / STEP + 1;
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v, input int stall);
    int edges;
    logic [W-1:0] hold;
    @(negedge clk);
    chk("in_ready_idle", W'(InReady), W'(1));
    Sm = v.sm; Se = v.se; Ss = v.ss; InValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_busy", W'(InReady), W'(0));
    // Garbage with InValid still high must be ignored while busy.
    Sm = {$urandom, $urandom, $urandom, $urandom, $urandom};
    Se = EW'($urandom); Ss = ~v.ss;
    edges = 0;
    while (edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (OutValid) break;
    end
    InValid = 1'b0;
    chk("out_valid", W'(OutValid), W'(1));
    chk("edges", W'(edges), W'(v.edges));
    chk("mf", Mf, v.mf);
    chk("me", W'(Me), W'(v.me));
    chk("ms", W'(Ms), W'(v.ss));
    chk("zero", W'(Zero), W'(v.zero));
    hold = Mf;
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", W'(OutValid), W'(1));
      chk("stall_ready", W'(InReady), W'(0));
      chk("stall_mf", Mf, hold);
      chk("stall_me", W'(Me), W'(v.me));
    end
    OutReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    OutReady = 1'b0;
    chk("ret_ready", W'(InReady), W'(1));
    chk("ret_valid", W'(OutValid), W'(0));
    chk("ret_mf", Mf, hold);
    chk("ret_zero", W'(Zero), W'(v.zero));
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    logic [W-1:0] one = 1;
    int bad_valid;

    tbl[0] = '{one<<159, 13'd1023, 1'b1, one<<159, 13'd1023, 1'b0, 1};
    tbl[1] = '{one,      13'd1000, 1'b0, one<<159, 13'd841,  1'b0, 10};
    tbl[2] = '{one<<100, 13'd20,   1'b0, one<<119, 13'd1,    1'b0, 2};
    tbl[3] = '{'0,       13'd500,  1'b1, '0,       13'd500,  1'b1, 1};
    tbl[4] = '{one<<100, 13'd0,    1'b1, one<<100, 13'd0,    1'b0, 1};
    tbl[5] = '{one<<100, 13'h1FFB, 1'b0, one<<100, 13'h1FFB, 1'b0, 1};
    tbl[6] = '{one<<127, 13'd100,  1'b0, one<<159, 13'd68,   1'b0, 3};
    tbl[7] = '{one<<100, 13'd17,   1'b1, one<<116, 13'd1,    1'b0, 2};
    tbl[8] = '{one<<100, 13'd1,    1'b0, one<<100, 13'd1,    1'b0, 1};

    reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Sm = '0; Se = '0; Ss = 1'b0;
    #12;
    chk("rst_in_ready", W'(InReady), W'(1));
    chk("rst_out_valid", W'(OutValid), W'(0));
    chk("rst_mf", Mf, '0);
    chk("rst_me", W'(Me), '0);
    chk("rst_ms", W'(Ms), '0);
    chk("rst_zero", W'(Zero), '0);
    @(negedge clk);
    reset_n = 1'b1;

    // First op accepted on the first edge after release.
    run_op(tbl[0], 5);
    for (int i = 1; i < 9; i++) run_op(tbl[i], i % 3);

    // Reset in the middle of a long shift.
    @(negedge clk);
    Sm = tbl[1].sm; Se = tbl[1].se; Ss = 1'b1; InValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    InValid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", W'(InReady), W'(1));
    chk("mid_rst_valid", W'(OutValid), W'(0));
    chk("mid_rst_mf", Mf, '0);
    chk("mid_rst_me", W'(Me), '0);
    chk("mid_rst_ms", W'(Ms), '0);
    @(negedge clk);
    reset_n = 1'b1;
    bad_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (OutValid) bad_valid++;
    end
    chk("post_rst_no_valid", W'(bad_valid), W'(0));
    run_op(tbl[2], 0);

    // Randomized operands against the reference.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] sm;
      int e;
      sm = {$urandom, $urandom, $urandom, $urandom, $urandom};
      sm = sm >> $urandom_range(0, W-1);
      if ($urandom_range(0, 9) == 0) sm = '0;
      e = int'($urandom_range(0, 1250)) - 50;
      v = model(sm, EW'(e), 1'($urandom));
      run_op(v, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fma_norm_seq.md
FMA_NORM_SEQ -- requirements
Module: fma_norm_seq

Interface
REQ-001 Parameter: NF, 52, fraction bits of widest format; sum width W = 3*NF+4 (160 at default).
REQ-002 Parameter: NE, 11, exponent bits; exponent ports are NE+2 bits, two's complement.
REQ-003 Parameter: STEP, 16, maximum left-shift per cycle; 1 <= STEP <= W.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 InValid  input  1  sum operands valid.
REQ-008 InReady  output  1  block accepts operands.
REQ-009 Sm  input  W  positive sum significand from the FMA adder.
REQ-010 Se  input  NE+2  sum exponent.
REQ-011 Ss  input  1  sum sign.
REQ-012 OutValid  output  1  normalized result valid.
REQ-013 OutReady  input  1  downstream accepts result.
REQ-014 Mf  output  W  normalized significand.
REQ-015 Me  output  NE+2  adjusted exponent.
REQ-016 Ms  output  1  result sign.
REQ-017 Zero  output  1  sum was exactly zero.

Function
REQ-018 States: IDLE, SHIFT, DONE; InReady = (state==IDLE); OutValid = (state==DONE).
REQ-019 IDLE: on InValid&InReady edge, capture Sm->Mf, Se->Me, Ss->Ms, clear Zero, go SHIFT; InValid low stays IDLE.
REQ-020 SHIFT, per cycle: L = leading-zero count of Mf[W-1:W-STEP], range 0..STEP.
REQ-021 SHIFT: if Mf==0, set Zero=1, leave Mf/Me unchanged, go DONE.
REQ-022 SHIFT: limit Lim = Me-1 when signed Me>=1, else 0; shift amount A = min(L, Lim).
REQ-023 SHIFT: Mf <= Mf<<A (zero fill); Me <= Me-A, computed NE+2 bits signed, no wrap possible since A<=Lim.
REQ-024 SHIFT: go DONE when L<STEP or A<L (exponent limit reached); else (L==STEP, A==STEP) stay SHIFT.
REQ-025 After a non-limited DONE with Zero=0, Mf[W-1]=1; after a limited DONE, Me=1 when entering with Me>=1, or Me unchanged when entering with Me<1.
REQ-026 Latency: accept edge, then k shift edges, k = floor(L_total/STEP)+1 (non-zero, non-limited); OutValid high after the k-th shift edge.
REQ-027 DONE: Mf, Me, Ms, Zero held stable while OutReady low; on OutReady edge go IDLE, outputs retain values.
REQ-028 Ms passes Ss unchanged, including Zero results; the block does no rounding or sign adjustment.
REQ-029 InReady low in SHIFT and DONE; inputs ignored there; no accept and deliver in the same cycle.
REQ-030 Mf, Me, Ms change only on the accept edge or SHIFT edges.

Reset
REQ-031 reset_n low forces immediately: state IDLE, InReady=1, OutValid=0, Mf=0, Me=0, Ms=0, Zero=0.
REQ-032 Reset asserted in SHIFT or DONE discards the operation; no OutValid follows release.
REQ-033 First accept is possible on the first rising edge after reset_n release with InValid high.

Verification
REQ-034 Sm=1<<159, Se=1023, Ss=1 -> OutValid after shift edge 1; Mf=1<<159, Me=1023, Ms=1, Zero=0.
REQ-035 Sm=1, Se=1000 -> 9 edges at L=16, 10th at L=15; OutValid after shift edge 10; Mf=1<<159, Me=841.
REQ-036 Sm=1<<100, Se=20 -> edge1 shift 16 (Me=4); edge2 limited shift 3; OutValid after edge 2; Mf=1<<119, Me=1.
REQ-037 Sm=0, Se=500, Ss=1 -> OutValid after shift edge 1; Zero=1, Mf=0, Me=500, Ms=1.
REQ-038 OutReady low 5 cycles in DONE -> outputs stable, InReady=0; OutReady high -> IDLE next edge, InReady=1.
REQ-039 reset_n low mid-SHIFT (case REQ-035, after edge 4) -> immediate reset values; no OutValid; next operand accepted normally.
